// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register bus between M0 (SPI controller) and M1 (sequencer).
// A master raises req with wr/addr/wdata stable and drops it in the single-cycle ack pulse.
module reg_bus_arbiter #(
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(7'h7F),
    parameter int                RD_WAIT   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_req,
    input  logic              i_m0_wr,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_wr,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic [ADDR_W-1:0] o_addr_bus,
    output logic [DATA_W-1:0] o_data_write_bus,
    output logic              o_wr_enable_bus,
    input  logic [DATA_W-1:0] i_data_read_bus,
    output logic              o_busy,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] RD_WAIT_CNT = 4'(RD_WAIT);

    state_t            state_q, state_d;
    logic              any_req, grant_m1;
    logic              owner_q, owner_d;   // 1 = M1 holds the current grant
    logic              last_q, last_d;     // 1 = M1 was served last
    logic              wr_q, wr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata0_d, rdata1_d;
    logic              wr_en_d, busy_d, ack0_d, ack1_d;

    assign any_req  = i_m0_req | i_m1_req;
    // Under contention the master not served last wins.
    assign grant_m1 = i_m1_req & (~i_m0_req | ~last_q);
    assign o_state  = state_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (wr_q || cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d  = owner_q;
        last_d   = last_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        addr_d   = o_addr_bus;
        wdata_d  = o_data_write_bus;
        rdata0_d = o_m0_rdata;
        rdata1_d = o_m1_rdata;
        busy_d   = o_busy;
        wr_en_d  = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = grant_m1;
                    addr_d  = grant_m1 ? i_m1_addr  : i_m0_addr;
                    wdata_d = grant_m1 ? i_m1_wdata : i_m0_wdata;
                    wr_d    = grant_m1 ? i_m1_wr    : i_m0_wr;
                    wr_en_d = grant_m1 ? i_m1_wr    : i_m0_wr;
                    busy_d  = 1'b1;
                    cnt_d   = RD_WAIT_CNT;
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    ack0_d = ~owner_q;
                    ack1_d = owner_q;
                end else if (cnt_q == 4'd0) begin
                    ack0_d = ~owner_q;
                    ack1_d = owner_q;
                    if (owner_q) rdata1_d = i_data_read_bus;
                    else         rdata0_d = i_data_read_bus;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                addr_d = IDLE_ADDR;
                busy_d = 1'b0;
                last_d = owner_q;
            end
            default: begin
                addr_d = IDLE_ADDR;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q          <= 1'b0;
            last_q           <= 1'b1;
            wr_q             <= 1'b0;
            cnt_q            <= 4'd0;
            o_addr_bus       <= IDLE_ADDR;
            o_data_write_bus <= '0;
            o_wr_enable_bus  <= 1'b0;
            o_busy           <= 1'b0;
            o_m0_ack         <= 1'b0;
            o_m1_ack         <= 1'b0;
            o_m0_rdata       <= '0;
            o_m1_rdata       <= '0;
        end else begin
            owner_q          <= owner_d;
            last_q           <= last_d;
            wr_q             <= wr_d;
            cnt_q            <= cnt_d;
            o_addr_bus       <= addr_d;
            o_data_write_bus <= wdata_d;
            o_wr_enable_bus  <= wr_en_d;
            o_busy           <= busy_d;
            o_m0_ack         <= ack0_d;
            o_m1_ack         <= ack1_d;
            o_m0_rdata       <= rdata0_d;
            o_m1_rdata       <= rdata1_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: transaction-level model checked every cycle,
// plus literal latency / ordering / reset expectations.
module tb_reg_bus_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int RD_WAIT = 1;
    localparam logic [ADDR_W-1:0] IDLE_A = 7'h7F;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_m0_req, i_m0_wr, i_m1_req, i_m1_wr;
    logic [ADDR_W-1:0] i_m0_addr, i_m1_addr;
    logic [DATA_W-1:0] i_m0_wdata, i_m1_wdata, i_data_read_bus;
    logic              o_m0_ack, o_m1_ack, o_wr_enable_bus, o_busy;
    logic [DATA_W-1:0] o_m0_rdata, o_m1_rdata, o_data_write_bus;
    logic [ADDR_W-1:0] o_addr_bus;
    logic [1:0]        o_state;

    reg_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDLE_ADDR(IDLE_A), .RD_WAIT(RD_WAIT)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_req(i_m0_req), .i_m0_wr(i_m0_wr), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
        .o_m0_ack(o_m0_ack), .o_m0_rdata(o_m0_rdata),
        .i_m1_req(i_m1_req), .i_m1_wr(i_m1_wr), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
        .o_m1_ack(o_m1_ack), .o_m1_rdata(o_m1_rdata),
        .o_addr_bus(o_addr_bus), .o_data_write_bus(o_data_write_bus),
        .o_wr_enable_bus(o_wr_enable_bus), .i_data_read_bus(i_data_read_bus),
        .o_busy(o_busy), .o_state(o_state)
    );

    // clock / reset / bookkeeping
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // model: one transaction at a time, tracked by its age in cycles since the grant edge
    bit                m_active;
    int                m_owner, m_last, m_age;
    bit                m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata0, m_rdata1;

    function automatic int ack_age(input bit wr);
        return wr ? 2 : RD_WAIT + 2;
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_active = 1'b0;
            m_last   = 1;
            m_age    = 0;
            m_owner  = 0;
            m_wr     = 1'b0;
            m_addr   = IDLE_A;
            m_wdata  = '0;
            m_rdata0 = '0;
            m_rdata1 = '0;
        end else if (m_active) begin
            m_age++;
            if (m_age == ack_age(m_wr) && !m_wr) begin
                if (m_owner == 1) m_rdata1 = i_data_read_bus;
                else              m_rdata0 = i_data_read_bus;
            end
            if (m_age > ack_age(m_wr)) begin
                m_active = 1'b0;
                m_last   = m_owner;
            end
        end else if (i_m0_req || i_m1_req) begin
            if (i_m0_req && i_m1_req) m_owner = 1 - m_last;
            else                      m_owner = i_m1_req ? 1 : 0;
            m_wr     = (m_owner == 1) ? i_m1_wr    : i_m0_wr;
            m_addr   = (m_owner == 1) ? i_m1_addr  : i_m0_addr;
            m_wdata  = (m_owner == 1) ? i_m1_wdata : i_m0_wdata;
            m_active = 1'b1;
            m_age    = 1;
        end
    end

    // scoreboard compare, every cycle out of reset
    always @(negedge i_clk) begin
        if (cmp_en && i_rst_n) begin
            chk("addr_bus",   32'(o_addr_bus),       32'(m_active ? m_addr : IDLE_A));
            chk("write_bus",  32'(o_data_write_bus), 32'(m_wdata));
            chk("wr_enable",  32'(o_wr_enable_bus),  32'(m_active && m_wr && m_age == 1));
            chk("busy",       32'(o_busy),           32'(m_active));
            chk("m0_ack",     32'(o_m0_ack),  32'(m_active && m_owner == 0 && m_age == ack_age(m_wr)));
            chk("m1_ack",     32'(o_m1_ack),  32'(m_active && m_owner == 1 && m_age == ack_age(m_wr)));
            chk("m0_rdata",   32'(o_m0_rdata),       32'(m_rdata0));
            chk("m1_rdata",   32'(o_m1_rdata),       32'(m_rdata1));
        end
    end

    // observed ack order and timing
    int ack_log[$];
    int ack_cyc[$];
    always @(negedge i_clk) begin
        if (o_m0_ack === 1'b1) begin ack_log.push_back(0); ack_cyc.push_back(cyc); end
        if (o_m1_ack === 1'b1) begin ack_log.push_back(1); ack_cyc.push_back(cyc); end
    end

    // driver tasks
    task automatic set_master(input int m, input bit wr, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
        if (m == 0) begin
            i_m0_wr = wr; i_m0_addr = a; i_m0_wdata = d; i_m0_req = 1'b1;
        end else begin
            i_m1_wr = wr; i_m1_addr = a; i_m1_wdata = d; i_m1_req = 1'b1;
        end
    endtask

    task automatic txn(input int m, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, output int lat, output int wr_cnt,
                       output logic [ADDR_W-1:0] wa, output logic [DATA_W-1:0] wd);
        int start;
        start  = cyc;
        lat    = -1;
        wr_cnt = 0;
        wa     = '0;
        wd     = '0;
        set_master(m, wr, a, d);
        for (int i = 0; i < 20 && lat < 0; i++) begin
            tick();
            if (o_wr_enable_bus) begin
                wr_cnt++;
                wa = o_addr_bus;
                wd = o_data_write_bus;
            end
            if ((m == 0) ? o_m0_ack : o_m1_ack) begin
                lat = cyc - start;
                if (m == 0) i_m0_req = 1'b0;
                else        i_m1_req = 1'b0;
            end
        end
        chk("txn_completed", 32'(lat >= 0), 32'(1));
        i_m0_req = 1'b0;
        i_m1_req = 1'b0;
    endtask

    task automatic multi(input bit hold, input int n_acks);
        int n;
        n = 0;
        for (int i = 0; i < 60 && n < n_acks; i++) begin
            tick();
            if (o_m0_ack) begin n++; if (!hold) i_m0_req = 1'b0; end
            if (o_m1_ack) begin n++; if (!hold) i_m1_req = 1'b0; end
        end
        chk("multi_ack_count", 32'(n), 32'(n_acks));
        i_m0_req = 1'b0;
        i_m1_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wrc;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        i_rst_n = 1'b1;
        i_m0_req = 0; i_m0_wr = 0; i_m0_addr = '0; i_m0_wdata = '0;
        i_m1_req = 0; i_m1_wr = 0; i_m1_addr = '0; i_m1_wdata = '0;
        i_data_read_bus = '0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_addr",   32'(o_addr_bus),       32'h7F);
        chk("rst_wdata",  32'(o_data_write_bus), 32'h00);
        chk("rst_wr_en",  32'(o_wr_enable_bus),  32'(0));
        chk("rst_busy",   32'(o_busy),           32'(0));
        chk("rst_acks",   32'({o_m0_ack, o_m1_ack}), 32'(0));
        chk("rst_rdata",  32'({o_m0_rdata, o_m1_rdata}), 32'(0));
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // single M0 write
        txn(0, 1'b1, 7'h05, 8'hA5, lat, wrc, wa, wd);
        chk("t1_latency",  32'(lat), 32'(2));
        chk("t1_wr_count", 32'(wrc), 32'(1));
        chk("t1_wr_addr",  32'(wa),  32'h05);
        chk("t1_wr_data",  32'(wd),  32'hA5);
        tick();
        chk("t1_addr_idle", 32'(o_addr_bus), 32'h7F);

        // single M1 read
        i_data_read_bus = 8'h3C;
        txn(1, 1'b0, 7'h10, 8'h00, lat, wrc, wa, wd);
        chk("t2_latency",  32'(lat), 32'(3));
        chk("t2_wr_count", 32'(wrc), 32'(0));
        chk("t2_rdata",    32'(o_m1_rdata), 32'h3C);
        tick();

        // simultaneous requests straight after reset, then again after an M0-only transaction
        do_reset();
        ack_log.delete();
        set_master(0, 1'b1, 7'h01, 8'h11);
        set_master(1, 1'b1, 7'h02, 8'h22);
        multi(1'b0, 2);
        tick();
        chk("t3a_count", 32'(ack_log.size()), 32'(2));
        if (ack_log.size() == 2) begin
            chk("t3a_first",  32'(ack_log[0]), 32'(0));
            chk("t3a_second", 32'(ack_log[1]), 32'(1));
        end
        txn(0, 1'b1, 7'h03, 8'h33, lat, wrc, wa, wd);
        tick();
        ack_log.delete();
        set_master(0, 1'b1, 7'h04, 8'h44);
        set_master(1, 1'b1, 7'h06, 8'h66);
        multi(1'b0, 2);
        tick();
        chk("t3b_count", 32'(ack_log.size()), 32'(2));
        if (ack_log.size() == 2) begin
            chk("t3b_first",  32'(ack_log[0]), 32'(1));
            chk("t3b_second", 32'(ack_log[1]), 32'(0));
        end

        // both hold req for six transactions; M0 was served last
        ack_log.delete();
        ack_cyc.delete();
        set_master(0, 1'b1, 7'h08, 8'h81);
        set_master(1, 1'b1, 7'h09, 8'h92);
        multi(1'b1, 6);
        tick();
        chk("t4_count", 32'(ack_log.size()), 32'(6));
        if (ack_log.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("t4_order", 32'(ack_log[i]), 32'((i % 2 == 0) ? 1 : 0));
            for (int i = 1; i < 6; i++) chk("t4_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(3));
        end

        // M1 arrives mid-transaction; M0 inputs change after its grant
        tick();
        ack_log.delete();
        i_data_read_bus = 8'h96;
        set_master(0, 1'b1, 7'h22, 8'h5A);
        tick();
        chk("t5_wr_en", 32'(o_wr_enable_bus),  32'(1));
        chk("t5_addr",  32'(o_addr_bus),       32'h22);
        chk("t5_data",  32'(o_data_write_bus), 32'h5A);
        set_master(1, 1'b0, 7'h10, 8'h00);
        i_m0_addr  = 7'h33;
        i_m0_wdata = 8'hFF;
        multi(1'b0, 2);
        chk("t5_rdata", 32'(o_m1_rdata), 32'h96);
        tick();
        chk("t5_count", 32'(ack_log.size()), 32'(2));
        if (ack_log.size() == 2) begin
            chk("t5_first",  32'(ack_log[0]), 32'(0));
            chk("t5_second", 32'(ack_log[1]), 32'(1));
        end

        // reset during a write ACCESS cycle
        tick();
        ack_log.delete();
        set_master(0, 1'b1, 7'h44, 8'h11);
        tick();
        chk("t6_wr_en_before", 32'(o_wr_enable_bus), 32'(1));
        #1 i_rst_n = 1'b0;
        #1;
        chk("t6_wr_en_reset", 32'(o_wr_enable_bus), 32'(0));
        chk("t6_addr_reset",  32'(o_addr_bus),      32'h7F);
        chk("t6_busy_reset",  32'(o_busy),          32'(0));
        i_m0_req = 1'b0;
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_no_ack", 32'(ack_log.size()), 32'(0));
        txn(0, 1'b1, 7'h45, 8'h12, lat, wrc, wa, wd);
        chk("t6_after_latency", 32'(lat), 32'(2));
        chk("t6_after_addr",    32'(wa),  32'h45);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
